// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB light sequence: checker states, the count-to-colour
// map and its inverse. The generator's golden model uses the same constants.
package rgb_seq_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } seq_state_t;

    // Indexed by count; element 0 is the last entry of the concatenation.
    localparam logic [7:0][2:0] RGB_CODE = {
        3'b000,  // 7
        3'b001,  // 6
        3'b101,  // 5
        3'b110,  // 4
        3'b100,  // 3
        3'b011,  // 2
        3'b010,  // 1
        3'b111   // 0
    };

    // The map is a bijection, so every rgb value finds exactly one count.
    function automatic logic [2:0] rgb_decode(input logic [2:0] rgb);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (RGB_CODE[i] == rgb) cnt = 3'(i);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rgb_code_decoder.sv
// Combinational inverse of the count-to-colour map: rgb code in, 3-bit count out.
module rgb_code_decoder
    import rgb_seq_pkg::*;
(
    input  logic [2:0] rgb,
    output logic [2:0] count
);

    always_comb begin
        count = rgb_decode(rgb);
    end

endmodule

// File: rtl/rgb_sequence_checker.sv
// Decodes the rgb light stream, locks onto the mod-8 up-count and reports
// count, lock status, wrap events and a saturating mismatch count.
module rgb_sequence_checker
    import rgb_seq_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 3,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       rgb_in,
    input  logic             rgb_valid,
    input  logic             err_clr,
    output logic [2:0]       count_out,
    output logic             count_valid,
    output logic             locked,
    output logic             seq_error,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count
);

    seq_state_t state;
    logic [2:0] prev;
    logic [2:0] dec;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;
    logic [2:0] prev_inc;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;
    logic       match;
    logic       err_sat;

    rgb_code_decoder u_dec (
        .rgb   (rgb_in),
        .count (dec)
    );

    assign prev_inc  = prev + 3'd1;
    assign match     = (dec == prev_inc);
    assign match_inc = match_cnt + 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;
    assign err_sat   = &err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            prev        <= 3'd0;
            match_cnt   <= 4'd0;
            miss_cnt    <= 4'd0;
            count_out   <= 3'd0;
            count_valid <= 1'b0;
            locked      <= 1'b0;
            seq_error   <= 1'b0;
            wrap        <= 1'b0;
            err_count   <= '0;
        end else begin
            count_valid <= 1'b0;
            seq_error   <= 1'b0;
            wrap        <= 1'b0;
            if (err_clr) err_count <= '0;

            if (rgb_valid) begin
                count_out   <= dec;
                count_valid <= 1'b1;
                prev        <= dec;
                case (state)
                    SEARCH: begin
                        state     <= TRACK;
                        match_cnt <= 4'd0;
                    end
                    TRACK: begin
                        if (!match) begin
                            match_cnt <= 4'd0;
                        end else if (match_inc == 4'(LOCK_COUNT)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            match_cnt <= 4'd0;
                            miss_cnt  <= 4'd0;
                        end else begin
                            match_cnt <= match_inc;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            miss_cnt <= 4'd0;
                            wrap     <= (prev == 3'd7);
                        end else begin
                            seq_error <= 1'b1;
                            // A clear on the same edge still records this error.
                            if (err_clr)       err_count <= ERR_W'(1);
                            else if (!err_sat) err_count <= err_count + 1'b1;
                            if (miss_inc == 4'(ERR_LIMIT)) begin
                                state     <= TRACK;
                                locked    <= 1'b0;
                                match_cnt <= 4'd0;
                                miss_cnt  <= 4'd0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgb_sequence_checker.sv
// Scenario bench for rgb_sequence_checker: each step queues the expected outputs,
// a monitor pops and compares them after the edge that consumes the sample.
module tb_rgb_sequence_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rgb_in;
    logic       rgb_valid;
    logic       err_clr;

    logic [2:0] count_out,   count_out2;
    logic       count_valid, count_valid2;
    logic       locked,      locked2;
    logic       seq_error,   seq_error2;
    logic       wrap,        wrap2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] c;
        logic       cv, lk, se, wr;
        int         ec;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    rgb_sequence_checker #(.LOCK_COUNT(3), .ERR_LIMIT(3), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .err_clr(err_clr),
        .count_out(count_out), .count_valid(count_valid), .locked(locked),
        .seq_error(seq_error), .wrap(wrap), .err_count(err_count)
    );

    // Narrow error counter copy, fed identically, to observe saturation.
    rgb_sequence_checker #(.LOCK_COUNT(3), .ERR_LIMIT(3), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .err_clr(err_clr),
        .count_out(count_out2), .count_valid(count_valid2), .locked(locked2),
        .seq_error(seq_error2), .wrap(wrap2), .err_count(err_count2)
    );

    always @(posedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            int   ec2;
            #1;
            e   = exp_q.pop_front();
            ec2 = (e.ec > 3) ? 3 : e.ec;
            n_checks += 6;
            if (count_out !== e.c)
                $display("FAIL count_out t=%0t got %0d want %0d", $time, count_out, e.c);
            else n_pass++;
            if (count_valid !== e.cv)
                $display("FAIL count_valid t=%0t got %b want %b", $time, count_valid, e.cv);
            else n_pass++;
            if (locked !== e.lk)
                $display("FAIL locked t=%0t got %b want %b", $time, locked, e.lk);
            else n_pass++;
            if (seq_error !== e.se)
                $display("FAIL seq_error t=%0t got %b want %b", $time, seq_error, e.se);
            else n_pass++;
            if (wrap !== e.wr)
                $display("FAIL wrap t=%0t got %b want %b", $time, wrap, e.wr);
            else n_pass++;
            if (err_count !== 8'(e.ec))
                $display("FAIL err_count t=%0t got %0d want %0d", $time, err_count, e.ec);
            else n_pass++;
            n_checks++;
            if (err_count2 !== 2'(ec2))
                $display("FAIL err_count_w2 t=%0t got %0d want %0d", $time, err_count2, ec2);
            else n_pass++;
        end
    end

    task automatic step(input logic rst, v, clr, input logic [2:0] rgb,
                        input logic [2:0] c, input logic cv, lk, se, wr, input int ec);
        exp_t e;
        reset     = rst;
        rgb_valid = v;
        err_clr   = clr;
        rgb_in    = rgb;
        e.c = c; e.cv = cv; e.lk = lk; e.se = se; e.wr = wr; e.ec = ec;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        step(1, 0, 0, 3'bxxx, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 3'b111, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 3'b010, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_lock_in;
        step(0, 1, 0, 3'b111, 0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 3'b010, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 3'b011, 2, 1, 0, 0, 0, 0);
        step(0, 1, 0, 3'b100, 3, 1, 1, 0, 0, 0);
    endtask

    task automatic test_wrap;
        step(0, 1, 0, 3'b110, 4, 1, 1, 0, 0, 0);
        step(0, 1, 0, 3'b101, 5, 1, 1, 0, 0, 0);
        step(0, 1, 0, 3'b001, 6, 1, 1, 0, 0, 0);
        step(0, 1, 0, 3'b000, 7, 1, 1, 0, 0, 0);
        step(0, 1, 0, 3'b111, 0, 1, 1, 0, 1, 0);
        step(0, 1, 0, 3'b010, 1, 1, 1, 0, 0, 0);
    endtask

    task automatic test_glitch;
        step(0, 1, 0, 3'b011, 2, 1, 1, 0, 0, 0);
        step(0, 1, 0, 3'b000, 7, 1, 1, 1, 0, 1);
        step(0, 1, 0, 3'b110, 4, 1, 1, 1, 0, 2);
        step(0, 1, 0, 3'b101, 5, 1, 1, 0, 0, 2);
        // walk round to count 4, taking a second wrap on the way
        step(0, 1, 0, 3'b001, 6, 1, 1, 0, 0, 2);
        step(0, 1, 0, 3'b000, 7, 1, 1, 0, 0, 2);
        step(0, 1, 0, 3'b111, 0, 1, 1, 0, 1, 2);
        step(0, 1, 0, 3'b010, 1, 1, 1, 0, 0, 2);
        step(0, 1, 0, 3'b011, 2, 1, 1, 0, 0, 2);
        step(0, 1, 0, 3'b100, 3, 1, 1, 0, 0, 2);
        step(0, 1, 0, 3'b110, 4, 1, 1, 0, 0, 2);
    endtask

    task automatic test_loss_of_lock;
        step(0, 1, 1, 3'b101, 5, 1, 1, 0, 0, 0);
        step(0, 1, 0, 3'b101, 5, 1, 1, 1, 0, 1);
        step(0, 1, 0, 3'b101, 5, 1, 1, 1, 0, 2);
        step(0, 1, 0, 3'b101, 5, 1, 0, 1, 0, 3);
        // mismatch in TRACK: no pulse, no count
        step(0, 1, 0, 3'b101, 5, 1, 0, 0, 0, 3);
        step(0, 1, 0, 3'b001, 6, 1, 0, 0, 0, 3);
        step(0, 1, 0, 3'b000, 7, 1, 0, 0, 0, 3);
        step(0, 1, 0, 3'b111, 0, 1, 1, 0, 0, 3);
    endtask

    task automatic test_valid_gaps;
        step(0, 0, 0, 3'bxxx, 0, 0, 1, 0, 0, 3);
        step(0, 1, 0, 3'b010, 1, 1, 1, 0, 0, 3);
        step(0, 0, 0, 3'b000, 1, 0, 1, 0, 0, 3);
        step(0, 0, 0, 3'bx1z, 1, 0, 1, 0, 0, 3);
        step(0, 1, 0, 3'b011, 2, 1, 1, 0, 0, 3);
        step(0, 0, 0, 3'b101, 2, 0, 1, 0, 0, 3);
        step(0, 1, 0, 3'b100, 3, 1, 1, 0, 0, 3);
    endtask

    task automatic test_clear;
        step(0, 1, 1, 3'b111, 0, 1, 1, 1, 0, 1);
        step(0, 1, 0, 3'b010, 1, 1, 1, 0, 0, 1);
        step(0, 0, 1, 3'bxxx, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic test_saturation;
        step(0, 1, 0, 3'b101, 5, 1, 1, 1, 0, 1);
        step(0, 1, 0, 3'b011, 2, 1, 1, 1, 0, 2);
        step(0, 1, 0, 3'b100, 3, 1, 1, 0, 0, 2);
        step(0, 1, 0, 3'b000, 7, 1, 1, 1, 0, 3);
        step(0, 1, 0, 3'b110, 4, 1, 1, 1, 0, 4);
        step(0, 1, 0, 3'b101, 5, 1, 1, 0, 0, 4);
        step(0, 1, 0, 3'b010, 1, 1, 1, 1, 0, 5);
        n_checks += 2;
        if (err_count2 !== 2'd3)
            $display("FAIL sat_w2_after5 got %0d want 3", err_count2);
        else n_pass++;
        if (locked2 !== 1'b1)
            $display("FAIL sat_w2_locked got %b want 1", locked2);
        else n_pass++;
        step(0, 1, 0, 3'b001, 6, 1, 1, 1, 0, 6);
        step(0, 1, 0, 3'b000, 7, 1, 1, 0, 0, 6);
    endtask

    task automatic test_reset_locked;
        n_checks++;
        if (locked !== 1'b1)
            $display("FAIL pre_reset_locked got %b want 1", locked);
        else n_pass++;
        step(1, 1, 0, 3'b111, 0, 0, 0, 0, 0, 0);
        // 010 is prev+1 of the reset prev, yet must only load prev
        step(0, 1, 0, 3'b010, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 3'b011, 2, 1, 0, 0, 0, 0);
        step(0, 1, 0, 3'b100, 3, 1, 0, 0, 0, 0);
        step(0, 1, 0, 3'b110, 4, 1, 1, 0, 0, 0);
    endtask

    initial begin
        reset     = 1'b1;
        rgb_valid = 1'b0;
        err_clr   = 1'b0;
        rgb_in    = 3'b000;
        test_reset();
        test_lock_in();
        test_wrap();
        test_glitch();
        test_loss_of_lock();
        test_valid_gaps();
        test_clear();
        test_saturation();
        test_reset_locked();
        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

endmodule
